me_sad_scheduler: RTL and testbench

- Sequences a bank of N_PE SAD processing elements through a full-search motion estimation run over N_GRP candidate groups.
- Each group is N_PE candidates evaluated in parallel. Per group the block clears the PEs, issues pixel read addresses and drives the PE enables aligned to 1-cycle memory read latency.
- After each group it compares the N_PE SAD results and tracks the global minimum SAD and its candidate index.
- Sits between the top-level ME control (start/done) and the PE array plus the template/search-window memories.

---
 rtl/me_sad_scheduler.sv | 162 ++++++++++++++++
 tb/tb_me_sad_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/me_sad_scheduler.sv
// Full-search ME scheduler: steps a bank of SAD PEs through N_GRP candidate groups,
// aligning PE enables to 1-cycle memory latency and tracking the global minimum SAD.
module me_sad_scheduler #(
  parameter  int N_PE  = 4,
  parameter  int BLK   = 4,
  parameter  int N_GRP = 4,
  parameter  int SAD_W = 16,
  localparam int NPIX  = BLK * BLK,
  localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1,
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int PE_W  = (N_PE > 1) ? $clog2(N_PE) : 1,
  localparam int IDX_W = (N_GRP * N_PE > 1) ? $clog2(N_GRP * N_PE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [GRP_W-1:0]        rd_grp,
  output logic [PIX_W-1:0]        rd_pix,
  output logic                    pe_clr,
  output logic                    pe_en,
  input  logic [N_PE*SAD_W-1:0]   sad_in,
  output logic [SAD_W-1:0]        best_sad,
  output logic [IDX_W-1:0]        best_idx
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, TAIL1, TAIL2, CMP, DONE} state_t;

  state_t             state_q, state_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [PIX_W-1:0]   rd_pix_q, rd_pix_d;
  logic               rd_en_q, rd_en_d;
  logic               pe_clr_q, pe_clr_d;
  logic               pe_en_q, pe_en_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;

  logic [N_PE-1:0][SAD_W-1:0] sad_lane;
  logic [SAD_W-1:0]           min_sad;
  logic [PE_W-1:0]            min_p;
  logic [IDX_W-1:0]           cand_idx;

  assign sad_lane = sad_in;

  // Strict '<' scanning upward keeps the lowest PE index on equal SADs.
  always_comb begin
    min_sad = sad_lane[0];
    min_p   = '0;
    for (int p = 1; p < N_PE; p++) begin
      if (sad_lane[p] < min_sad) begin
        min_sad = sad_lane[p];
        min_p   = PE_W'(p);
      end
    end
  end

  assign cand_idx = IDX_W'(grp_q) * IDX_W'(N_PE) + IDX_W'(min_p);

  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    rd_pix_d   = rd_pix_q;
    rd_en_d    = 1'b0;
    pe_clr_d   = 1'b0;
    // PE enable trails the read strobe by one cycle, plus one extra accumulate cycle.
    pe_en_d    = rd_en_q | (state_q == TAIL1);
    done_d     = 1'b0;
    busy_d     = busy_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLR;
          grp_d      = '0;
          rd_pix_d   = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          pe_clr_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      CLR: begin
        state_d  = RUN;
        rd_en_d  = 1'b1;
        rd_pix_d = '0;
      end
      RUN: begin
        if (rd_pix_q == PIX_W'(NPIX - 1)) begin
          state_d = TAIL1;
        end else begin
          rd_en_d  = 1'b1;
          rd_pix_d = rd_pix_q + PIX_W'(1);
        end
      end
      TAIL1: state_d = TAIL2;
      TAIL2: state_d = CMP;
      CMP: begin
        if (min_sad < best_sad_q) begin
          best_sad_d = min_sad;
          best_idx_d = cand_idx;
        end
        if (grp_q == GRP_W'(N_GRP - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d  = CLR;
          grp_d    = grp_q + GRP_W'(1);
          rd_pix_d = '0;
          pe_clr_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grp_q      <= '0;
      rd_pix_q   <= '0;
      rd_en_q    <= 1'b0;
      pe_clr_q   <= 1'b0;
      pe_en_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      best_sad_q <= '1;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      rd_pix_q   <= rd_pix_d;
      rd_en_q    <= rd_en_d;
      pe_clr_q   <= pe_clr_d;
      pe_en_q    <= pe_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  // busy covers the accepting cycle itself, hence the start term.
  assign busy     = busy_q | ((state_q == IDLE) & start & ~rst);
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_grp   = grp_q;
  assign rd_pix   = rd_pix_q;
  assign pe_clr   = pe_clr_q;
  assign pe_en    = pe_en_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: tb/tb_me_sad_scheduler.sv
// Randomized/directed bench for me_sad_scheduler against a flat candidate-scan model.
module tb_me_sad_scheduler;
  localparam int N_PE  = 4;
  localparam int BLK   = 4;
  localparam int N_GRP = 4;
  localparam int SAD_W = 16;
  localparam int NPIX  = BLK * BLK;
  localparam int GC    = NPIX + 4;
  localparam int DONE_C = N_GRP * GC + 1;

  logic clk = 1'b0;
  logic rst, start, busy, done, rd_en, pe_clr, pe_en;
  logic [1:0] rd_grp;
  logic [3:0] rd_pix;
  logic [N_PE*SAD_W-1:0] sad_in;
  logic [SAD_W-1:0] best_sad;
  logic [3:0] best_idx;

  logic [SAD_W-1:0] sad_tbl [N_GRP][N_PE];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  me_sad_scheduler #(.N_PE(N_PE), .BLK(BLK), .N_GRP(N_GRP), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_grp(rd_grp), .rd_pix(rd_pix), .pe_clr(pe_clr),
    .pe_en(pe_en), .sad_in(sad_in), .best_sad(best_sad), .best_idx(best_idx)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N_PE*SAD_W-1:0] pack(input int g);
    logic [N_PE*SAD_W-1:0] v;
    v = '0;
    for (int p = 0; p < N_PE; p++) v[p*SAD_W +: SAD_W] = sad_tbl[g][p];
    return v;
  endfunction

  // Reference: first candidate in index order holding the smallest SAD below all-ones.
  task automatic model(output longint bs, output longint bi);
    bs = (64'd1 << SAD_W) - 1;
    bi = 0;
    for (int k = 0; k < N_GRP * N_PE; k++)
      if (sad_tbl[k / N_PE][k % N_PE] < bs) begin
        bs = sad_tbl[k / N_PE][k % N_PE];
        bi = k;
      end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_pe_clr"}, pe_clr, 0);
    chk({tag, "_pe_en"}, pe_en, 0);
    chk({tag, "_rd_grp"}, rd_grp, 0);
    chk({tag, "_rd_pix"}, rd_pix, 0);
    chk({tag, "_best_idx"}, best_idx, 0);
    chk({tag, "_best_sad"}, best_sad, (64'd1 << SAD_W) - 1);
  endtask

  task automatic run(input string tag, input int mid_start, input int abort_at);
    int busy_cnt = 0, done_cnt = 0, done_c = -1, stray = 0;
    int first_ren = -1, first_pen = -1, pix_err = 0, grp_err = 0, exp_pix = 0;
    int pclr [N_GRP], ren [N_GRP], pen [N_GRP];
    longint bs, bi;
    for (int g = 0; g < N_GRP; g++) begin pclr[g] = 0; ren[g] = 0; pen[g] = 0; end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == mid_start);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        sad_in = pack(rd_grp);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk_reset_vals({tag, "_abort"});
        return;
      end
      #1;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_c = c; end
      if (c >= 1 && c <= N_GRP * GC) begin
        int g = (c - 1) / GC;
        if (rd_grp != g) grp_err++;
        pclr[g] += pe_clr;
        ren[g]  += rd_en;
        pen[g]  += pe_en;
        if (pe_clr) exp_pix = 0;
        if (rd_en) begin
          if (rd_pix != exp_pix) pix_err++;
          exp_pix++;
        end
        if (g == 0 && rd_en && first_ren < 0) first_ren = c;
        if (g == 0 && pe_en && first_pen < 0) first_pen = c;
      end else if (pe_clr || rd_en || pe_en) stray++;
      sad_in = pack(rd_grp);
      if (done_c >= 0 && c == done_c + 1) begin
        chk({tag, "_busy_after"}, busy, 0);
        break;
      end
    end
    start = 1'b0;
    if (done_c < 0) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_done_cyc"}, done_c, DONE_C);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_cnt"}, busy_cnt, DONE_C + 1);
    chk({tag, "_stray"}, stray, 0);
    chk({tag, "_pix_seq"}, pix_err, 0);
    chk({tag, "_grp_stable"}, grp_err, 0);
    chk({tag, "_pe_lag"}, first_pen - first_ren, 1);
    for (int g = 0; g < N_GRP; g++) begin
      chk($sformatf("%s_g%0d_clr", tag, g), pclr[g], 1);
      chk($sformatf("%s_g%0d_rden", tag, g), ren[g], NPIX);
      chk($sformatf("%s_g%0d_peen", tag, g), pen[g], NPIX + 1);
    end
    model(bs, bi);
    chk({tag, "_best_sad"}, best_sad, bs);
    chk({tag, "_best_idx"}, best_idx, bi);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_hold_sad"}, best_sad, bs);
    chk({tag, "_hold_idx"}, best_idx, bi);
  endtask

  task automatic fill_ramp();
    for (int g = 0; g < N_GRP; g++)
      for (int p = 0; p < N_PE; p++) sad_tbl[g][p] = SAD_W'(100 + 10 * g + p);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sad_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int g = 0; g < N_GRP; g++)
      for (int p = 0; p < N_PE; p++) sad_tbl[g][p] = '0;
    run("zero", -1, -1);

    fill_ramp();
    sad_tbl[2][3] = 7;
    run("ramp", -1, -1);

    for (int g = 0; g < N_GRP; g++)
      for (int p = 0; p < N_PE; p++) sad_tbl[g][p] = 50;
    sad_tbl[1][1] = 5; sad_tbl[1][2] = 5; sad_tbl[3][0] = 5;
    run("ties", -1, -1);

    fill_ramp();
    sad_tbl[2][3] = 7;
    run("midstart", 10, -1);

    fill_ramp();
    run("abort", -1, 25);
    for (int g = 0; g < N_GRP; g++)
      for (int p = 0; p < N_PE; p++) sad_tbl[g][p] = 200;
    sad_tbl[3][1] = 150;
    run("after_abort", -1, -1);

    for (int r = 0; r < 6; r++) begin
      for (int g = 0; g < N_GRP; g++)
        for (int p = 0; p < N_PE; p++)
          sad_tbl[g][p] = (r < 4) ? SAD_W'($urandom_range(0, 30)) : SAD_W'($urandom);
      run($sformatf("rand%0d", r), (r == 2) ? int'($urandom_range(1, 80)) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
